// File: rtl/csync_split.sv
// Composite sync separator: glitch-filtered hsync regeneration and width-classified vsync.
// Optional line-rate lock detector is enabled by defining CSYNC_SPLIT_LOCK_EN.
module csync_split #(
    parameter int CNT_WIDTH  = 9,
    parameter int MIN_HIGH   = 16,
    parameter int HS_WIDTH   = 64,
    parameter int VS_LOW     = 160,
    parameter int VS_HIGH    = 96,
    parameter int LINE_MIN   = 700,
    parameter int LINE_MAX   = 830,
    parameter int LOCK_LINES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic csync,
    output logic hsync,
    output logic vsync,
    output logic hedge,
    output logic locked
);

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO   = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] MIN_HIGH_C = CNT_WIDTH'(MIN_HIGH);
    localparam logic [CNT_WIDTH-1:0] HS_LAST_C  = CNT_WIDTH'(HS_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] VS_LOW_C   = CNT_WIDTH'(VS_LOW);
    localparam logic [CNT_WIDTH-1:0] VS_HIGH_C  = CNT_WIDTH'(VS_HIGH);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (v == CNT_MAX) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_ONE;
        end
    endfunction

    logic                 sync1_r;
    logic                 sync2_r;
    logic                 prev_r;
    logic                 fall_s;
    logic                 rise_s;
    logic                 accept_s;
    logic [CNT_WIDTH-1:0] hi_cnt_r;
    logic [CNT_WIDTH-1:0] lo_cnt_r;
    logic [CNT_WIDTH-1:0] hs_cnt_r;

    // Edge detection on the synchronized level; only falls after a long enough high run are line edges.
    always_comb begin
        fall_s   = prev_r & ~sync2_r;
        rise_s   = ~prev_r & sync2_r;
        accept_s = fall_s && (hi_cnt_r >= MIN_HIGH_C);
    end

    // Two-flop synchronizer plus history flop, idling at the inactive (high) level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            prev_r  <= 1'b1;
        end else begin
            sync1_r <= csync;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Saturating run-length counters for the high and low phases of csync.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_cnt_r <= CNT_ZERO;
            lo_cnt_r <= CNT_ZERO;
        end else begin
            if (fall_s) begin
                hi_cnt_r <= CNT_ZERO;
            end else if (sync2_r) begin
                hi_cnt_r <= sat_inc(hi_cnt_r);
            end else begin
                hi_cnt_r <= hi_cnt_r;
            end
            if (rise_s) begin
                lo_cnt_r <= CNT_ZERO;
            end else if (!sync2_r) begin
                lo_cnt_r <= sat_inc(lo_cnt_r);
            end else begin
                lo_cnt_r <= lo_cnt_r;
            end
        end
    end

    // Line-edge strobe and fixed-width hsync pulse; edges arriving mid-pulse do not retrigger it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hedge    <= 1'b0;
            hsync    <= 1'b1;
            hs_cnt_r <= CNT_ZERO;
        end else begin
            hedge <= accept_s;
            if (!hsync) begin
                if (hs_cnt_r == CNT_ZERO) begin
                    hsync <= 1'b1;
                end else begin
                    hs_cnt_r <= hs_cnt_r - CNT_ONE;
                end
            end else if (accept_s) begin
                hsync    <= 1'b0;
                hs_cnt_r <= HS_LAST_C;
            end else begin
                hsync <= 1'b1;
            end
        end
    end

    // Vsync follows long low runs and is released only by a high run longer than a serration blip.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync <= 1'b1;
        end else if (lo_cnt_r == VS_LOW_C) begin
            vsync <= 1'b0;
        end else if (hi_cnt_r == VS_HIGH_C) begin
            vsync <= 1'b1;
        end else begin
            vsync <= vsync;
        end
    end

`ifdef CSYNC_SPLIT_LOCK_EN
    localparam int                PER_W      = 12;
    localparam int                GOOD_W     = $clog2(LOCK_LINES + 1);
    localparam logic [PER_W-1:0]  PER_ZERO   = {PER_W{1'b0}};
    localparam logic [PER_W-1:0]  PER_ONE    = PER_W'(1);
    localparam logic [PER_W-1:0]  PER_MAX    = {PER_W{1'b1}};
    localparam logic [PER_W-1:0]  LINE_MIN_C = PER_W'(LINE_MIN);
    localparam logic [PER_W-1:0]  LINE_MAX_C = PER_W'(LINE_MAX);
    localparam logic [PER_W-1:0]  TIMEOUT_C  = PER_W'(LINE_MAX + LINE_MIN);
    localparam logic [GOOD_W-1:0] GOOD_ZERO  = {GOOD_W{1'b0}};
    localparam logic [GOOD_W-1:0] GOOD_ONE   = GOOD_W'(1);
    localparam logic [GOOD_W-1:0] LOCK_C     = GOOD_W'(LOCK_LINES);

    logic [PER_W-1:0]  period_r;
    logic [GOOD_W-1:0] good_r;
    logic [GOOD_W-1:0] good_next_s;
    logic              bad_r;
    logic              in_range_s;
    logic              timeout_s;

    // Classify the just-completed line period and pre-compute the saturating good count.
    always_comb begin
        in_range_s = (period_r >= LINE_MIN_C) && (period_r <= LINE_MAX_C);
        timeout_s  = period_r > TIMEOUT_C;
        if (good_r == LOCK_C) begin
            good_next_s = good_r;
        end else begin
            good_next_s = good_r + GOOD_ONE;
        end
    end

    // Lock tracker: one bad period (vsync phase jump) is tolerated, two in a row or a lost line drop lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_r <= PER_ZERO;
            good_r   <= GOOD_ZERO;
            bad_r    <= 1'b0;
            locked   <= 1'b0;
        end else if (hedge) begin
            period_r <= PER_ZERO;
            if (in_range_s) begin
                good_r <= good_next_s;
                bad_r  <= 1'b0;
                locked <= (good_next_s == LOCK_C);
            end else if (bad_r) begin
                good_r <= GOOD_ZERO;
                locked <= 1'b0;
            end else begin
                bad_r <= 1'b1;
            end
        end else begin
            if (period_r != PER_MAX) begin
                period_r <= period_r + PER_ONE;
            end else begin
                period_r <= period_r;
            end
            if (timeout_s) begin
                good_r <= GOOD_ZERO;
                bad_r  <= 1'b0;
                locked <= 1'b0;
            end else begin
                locked <= locked;
            end
        end
    end
`else
    assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_csync_split.sv
// Directed bench for csync_split: csync segment table with per-segment expected outputs,
// plus hand sequences for hsync pulse width and asynchronous reset in mid-pulse.
module tb_csync_split;

    logic clk = 1'b0;
    logic rst_n;
    logic csync;
    logic hsync;
    logic vsync;
    logic hedge;
    logic locked;

`ifdef CSYNC_SPLIT_LOCK_EN
    localparam bit LK_EN = 1'b1;
`else
    localparam bit LK_EN = 1'b0;
`endif

    csync_split dut (
        .clk   (clk),
        .rst_n (rst_n),
        .csync (csync),
        .hsync (hsync),
        .vsync (vsync),
        .hedge (hedge),
        .locked(locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit lvl;
        int cyc;
        int hedges;
        bit hs;
        bit vs;
        bit lk;
    } row_t;

    row_t tbl[$];
    int   errors    = 0;
    int   checks    = 0;
    int   hedge_cnt = 0;
    int   run_len   = 0;
    int   last_low  = 0;
    int   h0;

    // Count hedge strobes and measure hsync low-pulse lengths just after each active edge.
    always @(posedge clk) begin
        #1;
        if (hedge) hedge_cnt++;
        if (!hsync) begin
            run_len++;
        end else if (run_len != 0) begin
            last_low = run_len;
            run_len  = 0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(input bit lvl, input int cyc, input int hd,
                                input bit hs, input bit vs, input bit lk);
        row_t r;
        r.lvl = lvl; r.cyc = cyc; r.hedges = hd; r.hs = hs; r.vs = vs; r.lk = lk;
        tbl.push_back(r);
    endfunction

    // One 768-tick line: 64 low then 704 high.
    function automatic void line(input bit lk_lo, input bit lk_hi);
        add(1'b0, 64, 1, 1'b0, 1'b1, lk_lo);
        add(1'b1, 704, 0, 1'b1, 1'b1, lk_hi);
    endfunction

    initial begin
        // idle, then three normal lines
        add(1'b1, 1000, 0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) line(1'b0, 1'b0);
        // short high glitch inside the low run: the second fall must be rejected
        add(1'b0, 20, 1, 1'b0, 1'b1, 1'b0);
        add(1'b1, 5, 0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 40, 0, 1'b0, 1'b1, 1'b0);
        add(1'b1, 704, 0, 1'b1, 1'b1, 1'b0);
        // vertical block: vsync low exactly 163 clk after the fall
        add(1'b0, 162, 1, 1'b1, 1'b1, 1'b1);
        add(1'b0, 1, 0, 1'b1, 1'b0, 1'b1);
        add(1'b0, 541, 0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            add(1'b1, 64, 0, 1'b1, 1'b0, 1'b1);
            add(1'b0, 704, 1, 1'b1, 1'b0, 1'b1);
        end
        // release: vsync high exactly 99 clk after the rise
        add(1'b1, 98, 0, 1'b1, 1'b0, 1'b1);
        add(1'b1, 1, 0, 1'b1, 1'b1, 1'b1);
        add(1'b1, 101, 0, 1'b1, 1'b1, 1'b1);
        // stuck low, recovery, stuck high
        add(1'b0, 1000, 1, 1'b1, 1'b0, 1'b1);
        add(1'b1, 704, 0, 1'b1, 1'b1, 1'b0);
        add(1'b1, 1000, 0, 1'b1, 1'b1, 1'b0);
        // acquire lock, lose it by stuck-high timeout
        for (int i = 0; i < 4; i++) line(1'b0, 1'b0);
        line(1'b1, 1'b1);
        add(1'b1, 1600, 0, 1'b1, 1'b1, 1'b0);
        // re-acquire, single bad period kept, two consecutive bad periods drop lock
        for (int i = 0; i < 4; i++) line(1'b0, 1'b0);
        add(1'b0, 64, 1, 1'b0, 1'b1, 1'b1);
        add(1'b1, 336, 0, 1'b1, 1'b1, 1'b1);
        add(1'b0, 64, 1, 1'b0, 1'b1, 1'b1);
        add(1'b1, 704, 0, 1'b1, 1'b1, 1'b1);
        add(1'b0, 64, 1, 1'b0, 1'b1, 1'b1);
        add(1'b1, 336, 0, 1'b1, 1'b1, 1'b1);
        add(1'b0, 64, 1, 1'b0, 1'b1, 1'b1);
        add(1'b1, 336, 0, 1'b1, 1'b1, 1'b1);
        add(1'b0, 64, 1, 1'b0, 1'b1, 1'b0);
        add(1'b1, 704, 0, 1'b1, 1'b1, 1'b0);

        rst_n = 1'b0;
        csync = 1'b1;
        repeat (5) @(negedge clk);
        check("reset hsync", hsync, 1);
        check("reset vsync", vsync, 1);
        check("reset hedge", hedge, 0);
        check("reset locked", locked, 0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            h0    = hedge_cnt;
            csync = tbl[i].lvl;
            repeat (tbl[i].cyc) @(negedge clk);
            check($sformatf("row%0d hedges", i), hedge_cnt - h0, tbl[i].hedges);
            check($sformatf("row%0d hsync", i), hsync, tbl[i].hs);
            check($sformatf("row%0d vsync", i), vsync, tbl[i].vs);
            check($sformatf("row%0d locked", i), locked, tbl[i].lk & LK_EN);
        end
        check("hsync pulse width", last_low, 64);

        // asynchronous reset in the middle of an hsync pulse
        csync = 1'b0;
        repeat (10) @(negedge clk);
        check("mid pulse hsync", hsync, 0);
        #2 rst_n = 1'b0;
        #1;
        check("async rst hsync", hsync, 1);
        check("async rst vsync", vsync, 1);
        check("async rst hedge", hedge, 0);
        check("async rst locked", locked, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        h0    = hedge_cnt;
        repeat (30) @(negedge clk);
        check("post rst fall rejected", hedge_cnt - h0, 0);
        check("post rst hsync", hsync, 1);
        csync = 1'b1;
        repeat (704) @(negedge clk);
        csync = 1'b0;
        repeat (64) @(negedge clk);
        check("post rst line hedge", hedge_cnt - h0, 1);
        check("post rst line hsync", hsync, 0);
        csync = 1'b1;
        repeat (20) @(negedge clk);
        check("post rst pulse width", last_low, 64);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
